// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and line levels.
// The parity encoding matches the RX parity checker so both sides agree.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the byte latched for the current frame and the data bit counter.
// Presents the bit that will be on the line after the next edge, and flags the last data bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic                  bit_nx,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Indexed with the next count so the registered TX_OUT lines up with the counter.
  assign bit_nx   = data_q[cnt_d];
  assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load) begin
        data_q <= din;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted request, one serial bit per CLK.
//   state  | meaning
//   IDLE   | line high, not busy, waiting for Data_Valid
//   START  | start bit on the line
//   DATA   | data bits LSB first
//   PARITY | optional parity bit
//   STOP   | stop bit, then one idle cycle minimum
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e state_q, state_d;

  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  load;
  logic                  advance;
  logic                  ser_done;
  logic                  bit_nx;
  logic                  par_bit;
  logic                  tx_d;
  logic                  busy_d;
  logic [DATA_WIDTH-1:0] data_q;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .advance (advance),
    .din     (P_DATA),
    .data_q  (data_q),
    .bit_nx  (bit_nx),
    .ser_done(ser_done)
  );

  assign par_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START:  state_d = DATA;
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          advance = 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = 1'b1;
    case (state_d)
      IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
      end
      START:   tx_d = START_BIT;
      DATA:    tx_d = bit_nx;
      PARITY:  tx_d = par_bit;
      STOP:    tx_d = STOP_BIT;
      default: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      TX_OUT    <= LINE_IDLE;
      busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else begin
      state_q <= state_d;
      TX_OUT  <= tx_d;
      busy    <= busy_d;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random frames against a frame-level model.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int frame_no = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s frame %0d: observed %b expected %b", tag, frame_no, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, TX_OUT, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Expected line bits from the frame definition: start, data LSB first, parity, stop.
  task automatic build_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             output logic q[$]);
    int ones;
    q.delete();
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) begin
      ones = $countones(d);
      q.push_back(((ones % 2) == 1) ^ ptyp);
    end
    q.push_back(1'b1);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input bit mangle, input bit hold_dv);
    logic exp_q[$];
    build_frame(d, pen, ptyp, exp_q);
    frame_no++;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!hold_dv) Data_Valid = 1'b0;
      if (mangle && i == 3) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = ~pen;
        PAR_TYP    = ~ptyp;
      end
      chk($sformatf("tx_bit%0d", i), TX_OUT, exp_q[i]);
      chk($sformatf("busy_bit%0d", i), busy, 1'b1);
    end
    @(posedge CLK);
    @(negedge CLK);
    chk_idle("gap");
  endtask

  initial begin
    logic exp_q[$];
    logic [7:0] rd;
    logic rpen, rptyp;
    bit rmangle;

    // Reset with a pending request: reset wins.
    RST        = 1'b1;
    Data_Valid = 1'b1;
    P_DATA     = 8'h5A;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      chk_idle("rst");
    end
    RST        = 1'b0;
    Data_Valid = 1'b0;
    repeat (20) begin
      @(posedge CLK);
      @(negedge CLK);
      chk_idle("idle");
    end

    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with Data_Valid held high.
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    Data_Valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_idle("after_b2b");

    // Reset during data bit 4 of 0xF0.
    frame_no++;
    build_frame(8'hF0, 1'b0, 1'b0, exp_q);
    P_DATA     = 8'hF0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      Data_Valid = 1'b0;
      chk($sformatf("abort_tx_bit%0d", i), TX_OUT, exp_q[i]);
      chk($sformatf("abort_busy_bit%0d", i), busy, 1'b1);
    end
    RST        = 1'b1;
    Data_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_idle("abort_rst");
    RST        = 1'b0;
    Data_Valid = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      chk_idle("abort_idle");
    end
    run_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random frames, some with mid-frame input disturbance.
    for (int k = 0; k < 40; k++) begin
      rd      = 8'($urandom_range(0, 255));
      rpen    = 1'($urandom_range(0, 1));
      rptyp   = 1'($urandom_range(0, 1));
      rmangle = ($urandom_range(0, 3) == 0);
      run_frame(rd, rpen, rptyp, rmangle, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK);
        @(negedge CLK);
        chk_idle("rand_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one parallel byte per request into a frame of start bit, DATA_WIDTH data bits (LSB first), optional parity bit, and one stop bit.
- Transmit-side counterpart of the UART receiver path; parity convention matches the RX parity checker (PAR_TYP 0 = even, 1 = odd).
- Runs on the baud-rate clock: one serial bit per CLK cycle. Sits between the system-side data source and the TX pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
- CLK  input  1  baud-rate clock; all logic on posedge.
- RST  input  1  reset, synchronous, active-high.
- P_DATA  input  DATA_WIDTH  parallel data to send; sampled only on acceptance.
- Data_Valid  input  1  transmit request; accepted only when busy=0.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  output  1  serial line, idle high; registered.
- busy  output  1  high for every cycle a frame bit is on TX_OUT; registered.

Behaviour:
- Reset (RST=1 at posedge): state IDLE, TX_OUT=1, busy=0, bit counter=0, data/parity registers cleared. Reset mid-frame aborts immediately; the line returns high on that edge and no partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. At a posedge with Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and go to START. From that edge, TX_OUT=0 and busy=1, so latency from the accepting edge to the start bit is 0 cycles.
- START: lasts 1 cycle, then DATA with bit counter=0. TX_OUT=data[0].
- DATA: TX_OUT=data[cnt] for DATA_WIDTH cycles. After the cycle with cnt=DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: 1 cycle. TX_OUT = ^data when even, ~(^data) when odd, computed from the latched data.
- STOP: 1 cycle, TX_OUT=1, busy=1, then IDLE with busy=0.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10/11 at default).
- Minimum gap: one IDLE cycle between frames. Data_Valid held high continuously gives back-to-back frames separated by exactly 1 idle-high cycle.
- Data_Valid while busy=1 (including during STOP) is ignored, not queued. Changes to P_DATA/PAR_EN/PAR_TYP mid-frame do not affect the frame in flight.
- Simultaneous RST and Data_Valid: reset wins and nothing is accepted.
- Bit counter width is clog2(DATA_WIDTH); it never wraps within a frame.
- Outputs are registered: no combinational path from inputs to TX_OUT or busy.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1, shared with the RX parity checker;
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module: uart_tx_serializer, which holds the latched data register and bit counter, drives the current data bit, and flags the last bit (ser_done) to the FSM.
- Parity computation and the output mux stay in uart_tx.

Test Plan:
- Reset idle: hold RST 3 cycles, then idle with Data_Valid=0 for 20 cycles -> TX_OUT=1 and busy=0 on every cycle.
- 0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; busy high exactly 11 cycles. Parity is 0 because 0xA5 has four ones.
- 0xA5, PAR_EN=1, PAR_TYP=1 -> same sequence but the parity bit is 1. Also send 0x01 with odd parity -> parity bit 0.
- 0x3C, PAR_EN=0 -> sequence 0,0,0,1,1,1,1,0,0,1 (10 cycles). Toggling Data_Valid and P_DATA=0xFF mid-frame leaves the frame unchanged.
- Data_Valid held high with P_DATA=0x55 then 0xAA, no parity -> two 10-bit frames separated by exactly one TX_OUT=1, busy=0 cycle.
- Assert RST during data bit 4 of 0xF0 -> on that edge TX_OUT=1 and busy=0. The next Data_Valid with 0x0F produces a complete, correct frame.
